pc_ras_unit: RTL

Parametrised program-counter unit for the RAT CPU. It combines the PC source mux, the PC register with increment, and an internal hardware return-address stack (RAS) with overflow/underflow detection. It sits between the control unit (load/inc/select/call/ret) and the program ROM address input. It replaces the stand-alone PC mux and PC register pair.

---
 rtl/pc_ras_unit_if.sv | 34 +++
 rtl/pc_ras_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pc_ras_unit_if.sv
// rtl/pc_ras_unit_if.sv - control-unit <-> PC/RAS unit signal bundle
// master = control unit side, slave = pc_ras_unit side.
interface pc_ras_unit_if #(
  parameter int ADDR_W    = 10,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              PC_LD;
  logic              PC_INC;
  logic [1:0]        PC_MUX_SEL;
  logic [ADDR_W-1:0] FROM_IMMED;
  logic [ADDR_W-1:0] FROM_STACK;
  logic              CALL;
  logic              RET;
  logic              CLR_FLAGS;
  logic [ADDR_W-1:0] PC_COUNT;
  logic [ADDR_W-1:0] RAS_TOP;
  logic [CNT_W-1:0]  RAS_COUNT;
  logic              RAS_EMPTY;
  logic              RAS_FULL;
  logic              RAS_OVF;
  logic              RAS_UNF;

  modport master (
    output PC_LD, PC_INC, PC_MUX_SEL, FROM_IMMED, FROM_STACK, CALL, RET, CLR_FLAGS,
    input  PC_COUNT, RAS_TOP, RAS_COUNT, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
  );

  modport slave (
    input  PC_LD, PC_INC, PC_MUX_SEL, FROM_IMMED, FROM_STACK, CALL, RET, CLR_FLAGS,
    output PC_COUNT, RAS_TOP, RAS_COUNT, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
  );
endinterface

// File: rtl/pc_ras_unit.sv
// rtl/pc_ras_unit.sv - PC source mux, PC register and circular return-address stack
// The RAS keeps a top pointer mod RAS_DEPTH; a push when full overwrites the oldest entry.
module pc_ras_unit #(
  parameter int              ADDR_W    = 10,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] INTR_VEC = {ADDR_W{1'b1}}
) (
  input logic          CLK,
  input logic          RST,
  pc_ras_unit_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_mux;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_ras_top;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_swap;
  logic              w_ovf_ev;
  logic              w_unf_ev;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_top_nxt;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
  assign w_top_idx = r_top - PTR_W'(1);
  assign w_ras_top = w_empty ? '0 : r_ras[w_top_idx];

  assign w_push   = bus.CALL & ~bus.RET;
  assign w_pop    = bus.RET & ~bus.CALL;
  assign w_swap   = bus.CALL & bus.RET;
  assign w_ovf_ev = w_push & w_full;
  assign w_unf_ev = w_pop & w_empty;

  // Sel 3 reads the pre-edge top, so LD+sel3+RET jumps to the entry being popped.
  always_comb begin
    w_mux = bus.FROM_IMMED;
    case (bus.PC_MUX_SEL)
      2'd0:    w_mux = bus.FROM_IMMED;
      2'd1:    w_mux = bus.FROM_STACK;
      2'd2:    w_mux = INTR_VEC;
      default: w_mux = w_ras_top;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (bus.PC_LD) begin
      w_pc_nxt = w_mux;
    end else if (bus.PC_INC) begin
      w_pc_nxt = w_pc_inc;
    end
  end

  // CALL+RET on an empty stack has no top to replace, so it degrades to a plain push.
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_top;
    w_top_nxt   = r_top;
    w_count_nxt = r_count;
    if (w_push || (w_swap && w_empty)) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_top;
      w_top_nxt = r_top + PTR_W'(1);
      if (!w_full) begin
        w_count_nxt = r_count + CNT_W'(1);
      end
    end else if (w_swap) begin
      w_wr_en  = 1'b1;
      w_wr_idx = w_top_idx;
    end else if (w_pop && !w_empty) begin
      w_top_nxt   = w_top_idx;
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_pc    <= '0;
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_top   <= w_top_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_ev | (r_ovf & ~bus.CLR_FLAGS);
      r_unf   <= w_unf_ev | (r_unf & ~bus.CLR_FLAGS);
    end
  end

  // Entry storage needs no reset: RAS_TOP is masked while the count is zero.
  always_ff @(posedge CLK) begin
    if (RST && w_wr_en) begin
      r_ras[w_wr_idx] <= w_pc_inc;
    end
  end

  assign bus.PC_COUNT  = r_pc;
  assign bus.RAS_TOP   = w_ras_top;
  assign bus.RAS_COUNT = r_count;
  assign bus.RAS_EMPTY = w_empty;
  assign bus.RAS_FULL  = w_full;
  assign bus.RAS_OVF   = r_ovf;
  assign bus.RAS_UNF   = r_unf;
endmodule
